// File: rtl/ip_codma_data_fifo_mc_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ip_codma_data_fifo_mc_if : port bundle of the multi-channel CODMA FIFO   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface ip_codma_data_fifo_mc_if #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 8,
   parameter int NUM_CH = 2
);
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic                      wr_valid_i;
   logic [CH_W-1:0]           wr_ch_i;
   logic [DATA_W-1:0]         wr_data_i;
   logic                      wr_ready_o;
   logic                      stat_valid_i;
   logic [CH_W-1:0]           stat_ch_i;
   logic [DATA_W-1:0]         stat_data_i;
   logic [CH_W-1:0]           rd_ch_i;
   logic                      rd_pop_i;
   logic [DATA_W-1:0]         rd_data_o;
   logic                      rd_valid_o;
   logic [NUM_CH-1:0]         flush_i;
   logic                      err_clr_i;
   logic [NUM_CH*CNT_W-1:0]   count_o;
   logic [NUM_CH-1:0]         almost_full_o;
   logic                      stat_ovf_err_o;
   logic                      udf_err_o;
   logic [NUM_CH*CNT_W-1:0]   hwm_o;

   modport master (
      output wr_valid_i, wr_ch_i, wr_data_i, stat_valid_i, stat_ch_i, stat_data_i,
             rd_ch_i, rd_pop_i, flush_i, err_clr_i,
      input  wr_ready_o, rd_data_o, rd_valid_o, count_o, almost_full_o,
             stat_ovf_err_o, udf_err_o, hwm_o
   );

   modport slave (
      input  wr_valid_i, wr_ch_i, wr_data_i, stat_valid_i, stat_ch_i, stat_data_i,
             rd_ch_i, rd_pop_i, flush_i, err_clr_i,
      output wr_ready_o, rd_data_o, rd_valid_o, count_o, almost_full_o,
             stat_ovf_err_o, udf_err_o, hwm_o
   );
endinterface
`default_nettype wire

// File: rtl/ip_codma_data_fifo_mc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ip_codma_data_fifo_mc : per-channel read-phase data FIFOs with status     |
// | insert; high-water marks built only with CODMA_FIFO_HWM_EN. Rev 1.0       |
// +--------------------------------------------------------------------------+
module ip_codma_data_fifo_mc #(
   parameter int DATA_W    = 32,
   parameter int DEPTH     = 8,
   parameter int NUM_CH    = 2,
   parameter int AF_THRESH = 6
) (
   input  wire logic               clk_i,
   input  wire logic               reset_i,
   ip_codma_data_fifo_mc_if.slave  fifo
);
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int IDX_W = CNT_W - 1;

   logic [DATA_W-1:0] r_mem [NUM_CH][DEPTH];
   logic [CNT_W-1:0]  r_wp  [NUM_CH];
   logic [CNT_W-1:0]  r_rp  [NUM_CH];
   logic [CNT_W-1:0]  r_cnt [NUM_CH];
   logic [NUM_CH-1:0] r_af;
   logic              r_ovf;
   logic              r_udf;

   logic [NUM_CH-1:0] w_full, w_empty, w_push, w_pop;
   logic [CNT_W-1:0]  w_cnt_nxt [NUM_CH];
   logic [DATA_W-1:0] w_push_data, w_head;
   logic w_full_wr, w_flush_wr, w_full_st, w_flush_st, w_flush_rd;
   logic w_wr_ready, w_stat_ok, w_wr_ok, w_rd_valid, w_ovf_set, w_udf_set;

   always_comb begin
      w_full_wr  = 1'b0;
      w_flush_wr = 1'b0;
      w_full_st  = 1'b0;
      w_flush_st = 1'b0;
      w_flush_rd = 1'b0;
      w_rd_valid = 1'b0;
      w_head     = '0;
      w_full     = '0;
      w_empty    = '0;
      w_push     = '0;
      w_pop      = '0;
      for (int n = 0; n < NUM_CH; n++) begin
         w_full[n]  = (r_cnt[n] == CNT_W'(DEPTH));
         w_empty[n] = (r_cnt[n] == '0);
         if (fifo.wr_ch_i == CH_W'(n)) begin
            w_full_wr  = w_full[n];
            w_flush_wr = fifo.flush_i[n];
         end
         if (fifo.stat_ch_i == CH_W'(n)) begin
            w_full_st  = w_full[n];
            w_flush_st = fifo.flush_i[n];
         end
         if (fifo.rd_ch_i == CH_W'(n)) begin
            w_rd_valid = !w_empty[n];
            w_flush_rd = fifo.flush_i[n];
            w_head     = r_mem[n][r_rp[n][IDX_W-1:0]];
         end
      end

      // Status words take the single write port ahead of read-phase data.
      w_stat_ok   = fifo.stat_valid_i && !w_full_st && !w_flush_st;
      w_ovf_set   = fifo.stat_valid_i && !w_stat_ok;
      w_wr_ready  = !fifo.stat_valid_i && !w_full_wr && !w_flush_wr;
      w_wr_ok     = fifo.wr_valid_i && w_wr_ready;
      w_push_data = w_stat_ok ? fifo.stat_data_i : fifo.wr_data_i;
      w_udf_set   = fifo.rd_pop_i && !w_rd_valid && !w_flush_rd;

      for (int n = 0; n < NUM_CH; n++) begin
         w_push[n] = (w_stat_ok && (fifo.stat_ch_i == CH_W'(n))) ||
                     (w_wr_ok && (fifo.wr_ch_i == CH_W'(n)));
         w_pop[n]  = fifo.rd_pop_i && (fifo.rd_ch_i == CH_W'(n)) &&
                     !w_empty[n] && !fifo.flush_i[n];
         w_cnt_nxt[n] = fifo.flush_i[n] ? '0 :
                        r_cnt[n] + CNT_W'(w_push[n]) - CNT_W'(w_pop[n]);
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int n = 0; n < NUM_CH; n++) begin
            r_wp[n]  <= '0;
            r_rp[n]  <= '0;
            r_cnt[n] <= '0;
            for (int d = 0; d < DEPTH; d++) begin
               r_mem[n][d] <= '0;
            end
         end
         r_af  <= '0;
         r_ovf <= 1'b0;
         r_udf <= 1'b0;
      end else begin
         for (int n = 0; n < NUM_CH; n++) begin
            if (fifo.flush_i[n]) begin
               r_wp[n] <= '0;
               r_rp[n] <= '0;
            end else begin
               if (w_push[n]) begin
                  r_mem[n][r_wp[n][IDX_W-1:0]] <= w_push_data;
                  r_wp[n] <= r_wp[n] + CNT_W'(1);
               end
               if (w_pop[n]) begin
                  r_rp[n] <= r_rp[n] + CNT_W'(1);
               end
            end
            r_cnt[n] <= w_cnt_nxt[n];
            r_af[n]  <= (w_cnt_nxt[n] >= CNT_W'(AF_THRESH));
         end
         // A new error event wins over a coincident clear.
         r_ovf <= (r_ovf && !fifo.err_clr_i) || w_ovf_set;
         r_udf <= (r_udf && !fifo.err_clr_i) || w_udf_set;
      end
   end

   always_comb begin
      fifo.wr_ready_o     = w_wr_ready;
      fifo.rd_valid_o     = w_rd_valid;
      fifo.rd_data_o      = w_rd_valid ? w_head : '0;
      fifo.almost_full_o  = r_af;
      fifo.stat_ovf_err_o = r_ovf;
      fifo.udf_err_o      = r_udf;
      fifo.count_o        = '0;
      for (int n = 0; n < NUM_CH; n++) begin
         fifo.count_o[n*CNT_W +: CNT_W] = r_cnt[n];
      end
   end

`ifdef CODMA_FIFO_HWM_EN
   logic [CNT_W-1:0] r_hwm [NUM_CH];

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int n = 0; n < NUM_CH; n++) begin
            r_hwm[n] <= '0;
         end
      end else begin
         for (int n = 0; n < NUM_CH; n++) begin
            if (fifo.flush_i[n]) begin
               r_hwm[n] <= '0;
            end else if (w_cnt_nxt[n] > r_hwm[n]) begin
               r_hwm[n] <= w_cnt_nxt[n];
            end
         end
      end
   end

   always_comb begin
      fifo.hwm_o = '0;
      for (int n = 0; n < NUM_CH; n++) begin
         fifo.hwm_o[n*CNT_W +: CNT_W] = r_hwm[n];
      end
   end
`else
   assign fifo.hwm_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ip_codma_data_fifo_mc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ip_codma_data_fifo_mc : directed + random bench with a queue model.   |
// | Honours CODMA_FIFO_HWM_EN for the high-water expectations. Rev 1.0       |
// +--------------------------------------------------------------------------+
module tb_ip_codma_data_fifo_mc;
   localparam int DATA_W    = 32;
   localparam int DEPTH     = 8;
   localparam int NUM_CH    = 2;
   localparam int AF_THRESH = 6;
   localparam int CNT_W     = 4;
`ifdef CODMA_FIFO_HWM_EN
   localparam bit HWM_ON = 1'b1;
`else
   localparam bit HWM_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   ip_codma_data_fifo_mc_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_CH(NUM_CH)) bus ();

   ip_codma_data_fifo_mc #(
      .DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_CH(NUM_CH), .AF_THRESH(AF_THRESH)
   ) dut (
      .clk_i   (clk),
      .reset_i (rst),
      .fifo    (bus)
   );

   logic [31:0] mq [NUM_CH][$];
   logic        m_ovf, m_udf;
   int          m_hwm [NUM_CH];
   int          n_vec = 0;
   int          n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_vec++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic chk_state();
      for (int c = 0; c < NUM_CH; c++) begin
         chk($sformatf("count[%0d]", c), bus.count_o[c*CNT_W +: CNT_W], mq[c].size());
         chk($sformatf("almost_full[%0d]", c), bus.almost_full_o[c], mq[c].size() >= AF_THRESH);
         chk($sformatf("hwm[%0d]", c), bus.hwm_o[c*CNT_W +: CNT_W], HWM_ON ? m_hwm[c] : 0);
      end
      chk("stat_ovf_err", bus.stat_ovf_err_o, m_ovf);
      chk("udf_err", bus.udf_err_o, m_udf);
   endtask

   task automatic drive(input logic wv, input int wch, input logic [31:0] wd,
                        input logic sv, input int sch, input logic [31:0] sd,
                        input int rch, input logic pop, input logic [1:0] fl, input logic clr);
      bus.wr_valid_i   = wv;
      bus.wr_ch_i      = 1'(wch);
      bus.wr_data_i    = wd;
      bus.stat_valid_i = sv;
      bus.stat_ch_i    = 1'(sch);
      bus.stat_data_i  = sd;
      bus.rd_ch_i      = 1'(rch);
      bus.rd_pop_i     = pop;
      bus.flush_i      = fl;
      bus.err_clr_i    = clr;
   endtask

   // One clock: check outputs against the model, then advance the model by the edge.
   task automatic step(input logic wv, input int wch, input logic [31:0] wd,
                       input logic sv, input int sch, input logic [31:0] sd,
                       input int rch, input logic pop, input logic [1:0] fl, input logic clr);
      logic e_ready, e_rv, stat_ok, do_pop, ovf_set, udf_set;
      drive(wv, wch, wd, sv, sch, sd, rch, pop, fl, clr);
      #2;
      e_ready = !sv && (mq[wch].size() != DEPTH) && !fl[wch];
      e_rv    = (mq[rch].size() != 0);
      chk("wr_ready", bus.wr_ready_o, e_ready);
      chk("rd_valid", bus.rd_valid_o, e_rv);
      if (e_rv) chk("rd_data", bus.rd_data_o, mq[rch][0]);
      chk_state();

      stat_ok = sv && (mq[sch].size() < DEPTH) && !fl[sch];
      ovf_set = sv && !stat_ok;
      do_pop  = pop && e_rv && !fl[rch];
      udf_set = pop && !e_rv && !fl[rch];
      if (do_pop) void'(mq[rch].pop_front());
      if (stat_ok) mq[sch].push_back(sd);
      else if (wv && e_ready) mq[wch].push_back(wd);
      for (int c = 0; c < NUM_CH; c++) begin
         if (fl[c]) begin
            mq[c].delete();
            m_hwm[c] = 0;
         end else if (mq[c].size() > m_hwm[c]) begin
            m_hwm[c] = mq[c].size();
         end
      end
      m_ovf = (m_ovf && !clr) || ovf_set;
      m_udf = (m_udf && !clr) || udf_set;
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int ch, input logic [31:0] d);
      step(1'b1, ch, d, 1'b0, 0, 32'h0, 0, 1'b0, 2'b00, 1'b0);
   endtask

   task automatic pop_ch(input int ch);
      step(1'b0, 0, 32'h0, 1'b0, 0, 32'h0, ch, 1'b1, 2'b00, 1'b0);
   endtask

   task automatic idle(input int rch);
      step(1'b0, 0, 32'h0, 1'b0, 0, 32'h0, rch, 1'b0, 2'b00, 1'b0);
   endtask

   // Reset asserted while other inputs are busy; everything must come back as zero.
   task automatic do_reset();
      rst = 1'b1;
      drive(1'b1, 0, $urandom, 1'b1, 1, $urandom, 0, 1'b1, 2'b00, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive(1'b0, 0, 32'h0, 1'b0, 0, 32'h0, 0, 1'b0, 2'b00, 1'b0);
      for (int c = 0; c < NUM_CH; c++) begin
         mq[c].delete();
         m_hwm[c] = 0;
      end
      m_ovf = 1'b0;
      m_udf = 1'b0;
      #1;
      chk("rst rd_valid", bus.rd_valid_o, 1'b0);
      chk("rst rd_data", bus.rd_data_o, 32'h0);
      chk("rst count", bus.count_o, 8'h00);
      chk("rst almost_full", bus.almost_full_o, 2'b00);
      chk("rst hwm", bus.hwm_o, 8'h00);
      chk("rst stat_ovf_err", bus.stat_ovf_err_o, 1'b0);
      chk("rst udf_err", bus.udf_err_o, 1'b0);
   endtask

   initial begin
      drive(1'b0, 0, 32'h0, 1'b0, 0, 32'h0, 0, 1'b0, 2'b00, 1'b0);
      m_ovf = 1'b0;
      m_udf = 1'b0;
      @(posedge clk);
      #1;
      do_reset();

      // Fill ch0 past full, then drain in order.
      for (int i = 0; i < DEPTH; i++) push(0, 32'hA0 + i);
      push(0, 32'hA8);
      for (int i = 0; i < DEPTH; i++) pop_ch(0);
      idle(0);

      // Cross-channel push/pop, then streaming through the wrap at count 3.
      for (int i = 0; i < 3; i++) push(0, 32'hB0 + i);
      step(1'b1, 1, 32'h11, 1'b0, 0, 32'h0, 0, 1'b1, 2'b00, 1'b0);
      push(0, 32'hB3);
      for (int i = 0; i < 20; i++) step(1'b1, 0, 32'hC0 + i, 1'b0, 0, 32'h0, 0, 1'b1, 2'b00, 1'b0);
      idle(0);

      // Status and data both targeting ch0; status wins.
      step(1'b1, 0, 32'hDEAD, 1'b1, 0, 32'h5A5A0001, 0, 1'b0, 2'b00, 1'b0);
      for (int i = 0; i < 7; i++) push(1, 32'hD0 + i);
      step(1'b0, 0, 32'h0, 1'b1, 1, 32'h5A5A0002, 1, 1'b0, 2'b00, 1'b0);
      idle(1);
      step(1'b0, 0, 32'h0, 1'b0, 0, 32'h0, 1, 1'b0, 2'b00, 1'b1);
      idle(1);

      // Underflow on empty ch1, then flush of a loaded ch0 with a concurrent pop.
      for (int i = 0; i < DEPTH; i++) pop_ch(1);
      pop_ch(1);
      idle(1);
      step(1'b0, 0, 32'h0, 1'b0, 0, 32'h0, 1, 1'b0, 2'b00, 1'b1);
      step(1'b0, 0, 32'h0, 1'b0, 0, 32'h0, 0, 1'b0, 2'b01, 1'b0);
      for (int i = 0; i < 5; i++) push(0, 32'hE0 + i);
      step(1'b0, 0, 32'h0, 1'b0, 0, 32'h0, 0, 1'b1, 2'b01, 1'b0);
      idle(0);

      // Mid-stream reset, then fresh traffic.
      for (int i = 0; i < 4; i++) push(0, 32'hF0 + i);
      do_reset();
      push(0, 32'h55);
      idle(0);
      pop_ch(0);

      // High-water mark: fill to 7, drain to 2, then flush.
      for (int i = 0; i < 7; i++) push(0, 32'h70 + i);
      for (int i = 0; i < 5; i++) pop_ch(0);
      idle(0);
      step(1'b0, 0, 32'h0, 1'b0, 0, 32'h0, 0, 1'b0, 2'b01, 1'b0);
      idle(0);

      // Random traffic against the model.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 149) == 0) begin
            do_reset();
         end else begin
            step(1'($urandom_range(0, 1)), $urandom_range(0, 1), $urandom,
                 1'($urandom_range(0, 7) == 0), $urandom_range(0, 1), $urandom,
                 $urandom_range(0, 1), 1'($urandom_range(0, 2) != 0),
                 {1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 19) == 0)},
                 1'($urandom_range(0, 11) == 0));
         end
      end
      idle(0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
